branch_predictor: RTL and testbench

//  IF-stage direction/target predictor; the front end of the branch path whose back end is the EX-stage

---
 rtl/branch_predictor_pkg.sv | 23 ++
 rtl/branch_predictor_if.sv | 39 +++
 rtl/bp_sat_ctr.sv | 28 ++
 rtl/branch_predictor.sv | 118 +++++++++++
 tb/tb_branch_predictor.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the IF-stage branch predictor.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package branch_predictor_pkg;

  // 2-bit direction counter states, strongly not-taken .. strongly taken.
  typedef enum logic [1:0] {
    BP_CTR_SNT = 2'b00,
    BP_CTR_WNT = 2'b01,
    BP_CTR_WT  = 2'b10,
    BP_CTR_ST  = 2'b11
  } bp_ctr_e;

  // Counter value after reset, and the value a freshly allocated entry starts with.
  localparam bp_ctr_e BP_CTR_INIT  = BP_CTR_WNT;
  localparam bp_ctr_e BP_CTR_ALLOC = BP_CTR_WT;

  // Sequential fall-through address; wraps 0xFFFFFFFC -> 0x00000000.
  function automatic logic [31:0] bp_pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Bundle between the pipeline (fetch lookup + EX resolve) and the branch predictor.
// Latency: none (wires only).
// Backpressure: none; the pipeline owns stalls and marks real EX work with ex_valid.
//
// Ports (from the predictor's side, modport slave):
//   in : if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target
//   out: pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, mispred_cnt
interface branch_predictor_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      if_pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             ex_valid;
  logic             ex_is_branch;
  logic [31:0]      ex_pc;
  logic             ex_taken;
  logic [31:0]      ex_target;
  logic             ex_pred_taken;
  logic [31:0]      ex_pred_target;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  // Pipeline side.
  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, mispred_cnt
  );

  // Predictor side.
  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/bp_sat_ctr.sv
// Next-state function of one 2-bit saturating direction counter.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   i_ctr   current counter state
//   i_taken resolved branch direction
//   o_ctr   next counter state (+1 on taken, -1 on not-taken, clamped at 00/11)
module bp_sat_ctr
  import branch_predictor_pkg::*;
(
  input  bp_ctr_e i_ctr,
  input  logic    i_taken,
  output bp_ctr_e o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    case (i_ctr)
      BP_CTR_SNT: o_ctr = i_taken ? BP_CTR_WNT : BP_CTR_SNT;
      BP_CTR_WNT: o_ctr = i_taken ? BP_CTR_WT  : BP_CTR_SNT;
      BP_CTR_WT:  o_ctr = i_taken ? BP_CTR_ST  : BP_CTR_WNT;
      BP_CTR_ST:  o_ctr = i_taken ? BP_CTR_ST  : BP_CTR_WT;
      default:    o_ctr = i_ctr;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage direction/target predictor: direct-mapped BTB with 2-bit counters, trained from EX.
// Latency: lookup and mispredict/redirect are combinational; training lands at the next clock edge.
// Backpressure: none; EX work is only consumed when ex_valid & ex_is_branch.
//
// Ports:
//   clk, rst  rising-edge clock, synchronous active-high reset
//   bp        branch_predictor_if.slave: fetch lookup (if_pc -> pred_*), EX resolve
//             (ex_* -> mispredict/redirect_pc), statistics (branch_cnt, mispred_cnt)
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  // BTB state. Valid and counter bits are reset; tag/target are only
  // meaningful behind a set valid bit, so they carry no reset.
  logic [ENTRIES-1:0]        r_valid;
  logic [ENTRIES-1:0][1:0]   r_ctr;
  logic [TAG_W-1:0]          r_tag    [ENTRIES];
  logic [31:0]               r_target [ENTRIES];

  logic [CNT_W-1:0]          r_branch_cnt;
  logic [CNT_W-1:0]          r_mispred_cnt;

  logic [IDX_W-1:0]          w_if_idx;
  logic [TAG_W-1:0]          w_if_tag;
  logic                      w_if_hit;
  logic                      w_pred_taken;

  logic [IDX_W-1:0]          w_ex_idx;
  logic [TAG_W-1:0]          w_ex_tag;
  logic                      w_ex_hit;
  logic                      w_upd;
  logic                      w_mispredict;
  bp_ctr_e                   w_ex_ctr;
  bp_ctr_e                   w_ctr_next;

  // ------------------------------------------------------------------
  // Fetch-side lookup: reads the array as it stands before this cycle's
  // training write, so a same-index update is only seen next cycle.
  // ------------------------------------------------------------------
  assign w_if_idx     = bp.if_pc[IDX_W+1:2];
  assign w_if_tag     = bp.if_pc[31:IDX_W+2];
  assign w_if_hit     = r_valid[w_if_idx] & (r_tag[w_if_idx] == w_if_tag);
  // Counter MSB set means weakly/strongly taken.
  assign w_pred_taken = ~rst & w_if_hit & r_ctr[w_if_idx][1];

  assign bp.pred_taken  = w_pred_taken;
  assign bp.pred_target = w_pred_taken ? r_target[w_if_idx] : bp_pc_plus4(bp.if_pc);

  // ------------------------------------------------------------------
  // EX-side resolve. Reset suppresses both the flush and any training.
  // ------------------------------------------------------------------
  assign w_ex_idx = bp.ex_pc[IDX_W+1:2];
  assign w_ex_tag = bp.ex_pc[31:IDX_W+2];
  assign w_ex_hit = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);
  assign w_upd    = ~rst & bp.ex_valid & bp.ex_is_branch;

  // A correctly predicted not-taken branch carries no meaningful target,
  // so the target only matters when the branch was actually taken.
  assign w_mispredict = w_upd &
                        ((bp.ex_taken != bp.ex_pred_taken) |
                         (bp.ex_taken & (bp.ex_target != bp.ex_pred_target)));

  assign bp.mispredict  = w_mispredict;
  assign bp.redirect_pc = bp.ex_taken ? bp.ex_target : bp_pc_plus4(bp.ex_pc);

  assign bp.branch_cnt  = r_branch_cnt;
  assign bp.mispred_cnt = r_mispred_cnt;

  assign w_ex_ctr = bp_ctr_e'(r_ctr[w_ex_idx]);

  bp_sat_ctr u_sat_ctr (
    .i_ctr   (w_ex_ctr),
    .i_taken (bp.ex_taken),
    .o_ctr   (w_ctr_next)
  );

  // ------------------------------------------------------------------
  // Training and statistics.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid       <= '0;
      r_ctr         <= {ENTRIES{BP_CTR_INIT}};
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (w_upd) begin
      r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_mispredict) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end

      if (w_ex_hit) begin
        r_ctr[w_ex_idx] <= w_ctr_next;
        if (bp.ex_taken) begin
          r_target[w_ex_idx] <= bp.ex_target;
        end
      end else if (bp.ex_taken) begin
        // Taken miss claims the slot, evicting any alias; not-taken miss
        // leaves the array alone so cold fall-through code costs nothing.
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= bp.ex_target;
        r_ctr[w_ex_idx]    <= BP_CTR_ALLOC;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int IDX_W = 6;
  localparam int CNT_W = 6;
  localparam int CNT_MOD = 1 << CNT_W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_predictor_if #(.CNT_W(CNT_W)) bp ();

  branch_predictor #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  // Reference model: sparse table keyed by slot number, presence == valid.
  typedef struct {
    logic [31:0] tag;
    logic [31:0] target;
    int          strength;   // 0..3, >=2 predicts taken
  } ent_t;

  ent_t        btb [int];
  int unsigned n_br;
  int unsigned n_mis;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) % (1 << IDX_W));
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int s;
    s = slot_of(pc);
    return btb.exists(s) && (btb[s].tag == tag_of(pc));
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output bit taken,
                                        output logic [31:0] tgt);
    taken = 1'b0;
    tgt   = pc + 32'd4;
    if (model_hit(pc) && btb[slot_of(pc)].strength >= 2) begin
      taken = 1'b1;
      tgt   = btb[slot_of(pc)].target;
    end
  endfunction

  function automatic bit model_mispredict();
    if (rst || !(bp.ex_valid && bp.ex_is_branch)) return 1'b0;
    return (bp.ex_taken != bp.ex_pred_taken) ||
           (bp.ex_taken && (bp.ex_target != bp.ex_pred_target));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at the same edge the DUT trains on.
  always @(posedge clk) begin
    if (rst) begin
      btb.delete();
      n_br  = 0;
      n_mis = 0;
    end else if (bp.ex_valid && bp.ex_is_branch) begin
      int s;
      s = slot_of(bp.ex_pc);
      n_br++;
      if (model_mispredict()) n_mis++;
      if (model_hit(bp.ex_pc)) begin
        if (bp.ex_taken) begin
          btb[s].strength = (btb[s].strength < 3) ? btb[s].strength + 1 : 3;
          btb[s].target   = bp.ex_target;
        end else begin
          btb[s].strength = (btb[s].strength > 0) ? btb[s].strength - 1 : 0;
        end
      end else if (bp.ex_taken) begin
        btb[s] = '{tag: tag_of(bp.ex_pc), target: bp.ex_target, strength: 2};
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      bit          ept;
      logic [31:0] etgt;
      logic [31:0] eredir;
      model_predict(bp.if_pc, ept, etgt);
      if (rst) begin
        ept  = 1'b0;
        etgt = bp.if_pc + 32'd4;
      end
      eredir = bp.ex_taken ? bp.ex_target : bp.ex_pc + 32'd4;
      check("cyc_pred_taken",  64'(bp.pred_taken),  64'(ept));
      check("cyc_pred_target", 64'(bp.pred_target), 64'(etgt));
      check("cyc_mispredict",  64'(bp.mispredict),  64'(model_mispredict()));
      check("cyc_redirect_pc", 64'(bp.redirect_pc), 64'(eredir));
      check("cyc_branch_cnt",  64'(bp.branch_cnt),  64'(n_br % CNT_MOD));
      check("cyc_mispred_cnt", 64'(bp.mispred_cnt), 64'(n_mis % CNT_MOD));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bp.ex_valid       = 1'b0;
    bp.ex_is_branch   = 1'b0;
    bp.ex_pc          = 32'h0;
    bp.ex_taken       = 1'b0;
    bp.ex_target      = 32'h0;
    bp.ex_pred_taken  = 1'b0;
    bp.ex_pred_target = 32'h0;
  endtask

  task automatic drive_br(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                          input bit ptaken, input logic [31:0] ptgt);
    bp.ex_valid       = 1'b1;
    bp.ex_is_branch   = 1'b1;
    bp.ex_pc          = pc;
    bp.ex_taken       = taken;
    bp.ex_target      = tgt;
    bp.ex_pred_taken  = ptaken;
    bp.ex_pred_target = ptgt;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    if ($urandom_range(0, 49) == 0) return 32'hFFFF_FFFC;
    pc = 32'h0040_0000 + ($urandom_range(0, 2) << 8) + ($urandom_range(0, 7) << 2);
    return pc;
  endfunction

  initial begin
    rst       = 1'b1;
    bp.if_pc  = 32'h0040_0010;
    idle();

    // Reset, with a would-be mispredicting branch sitting in EX.
    tick();
    check_en = 1'b1;
    drive_br(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
    #2;
    check("rst_mispredict", 64'(bp.mispredict), 64'd0);
    tick();
    rst = 1'b0;
    idle();
    #2;
    check("post_rst_pred_taken",  64'(bp.pred_taken),  64'd0);
    check("post_rst_pred_target", 64'(bp.pred_target), 64'h0040_0014);
    check("post_rst_branch_cnt",  64'(bp.branch_cnt),  64'd0);
    check("post_rst_mispred_cnt", 64'(bp.mispred_cnt), 64'd0);

    // Cold taken branch; lookup in the same cycle still sees the old entry.
    tick();
    drive_br(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
    #2;
    check("cold_mispredict",   64'(bp.mispredict),  64'd1);
    check("cold_redirect",     64'(bp.redirect_pc), 64'h0040_0040);
    check("same_cycle_old",    64'(bp.pred_taken),  64'd0);
    tick();
    idle();
    #2;
    check("alloc_pred_taken",  64'(bp.pred_taken),  64'd1);
    check("alloc_pred_target", 64'(bp.pred_target), 64'h0040_0040);
    check("alloc_mispred_cnt", 64'(bp.mispred_cnt), 64'd1);

    // Three more taken (saturate), then two not-taken.
    for (int i = 0; i < 3; i++) begin
      tick();
      drive_br(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0040);
      #2;
      check("sat_correct_mispredict", 64'(bp.mispredict), 64'd0);
    end
    tick();
    drive_br(32'h0040_0010, 1'b0, 32'h0040_0040, 1'b1, 32'h0040_0040);
    #2;
    check("nt1_mispredict", 64'(bp.mispredict),  64'd1);
    check("nt1_redirect",   64'(bp.redirect_pc), 64'h0040_0014);
    tick();
    idle();
    #2;
    check("nt1_still_taken", 64'(bp.pred_taken), 64'd1);
    tick();
    drive_br(32'h0040_0010, 1'b0, 32'h0040_0040, 1'b1, 32'h0040_0040);
    #2;
    check("nt2_mispredict", 64'(bp.mispredict), 64'd1);
    tick();
    idle();
    #2;
    check("nt2_pred_taken",  64'(bp.pred_taken),  64'd0);
    check("nt2_pred_target", 64'(bp.pred_target), 64'h0040_0014);
    check("nt2_branch_cnt",  64'(bp.branch_cnt),  64'd6);
    check("nt2_mispred_cnt", 64'(bp.mispred_cnt), 64'd3);

    // Alias eviction: 0x00400110 shares the slot of 0x00400010.
    tick();
    drive_br(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
    tick();
    idle();
    #2;
    check("retrain_taken", 64'(bp.pred_taken), 64'd1);
    tick();
    drive_br(32'h0040_0110, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0114);
    tick();
    idle();
    bp.if_pc = 32'h0040_0010;
    #1;
    check("alias_evicted", 64'(bp.pred_taken), 64'd0);
    bp.if_pc = 32'h0040_0110;
    #1;
    check("alias_new_taken",  64'(bp.pred_taken),  64'd1);
    check("alias_new_target", 64'(bp.pred_target), 64'h0040_0200);
    bp.if_pc = 32'hFFFF_FFFC;
    bp.ex_pc = 32'hFFFF_FFFC;
    #1;
    check("wrap_pred_target", 64'(bp.pred_target), 64'h0);
    check("wrap_redirect",    64'(bp.redirect_pc), 64'h0);

    // Randomized traffic over a small aliasing PC pool.
    for (int c = 0; c < 3000; c++) begin
      bit          mt;
      logic [31:0] mtgt;
      logic [31:0] epc;
      tick();
      rst = ($urandom_range(0, 299) == 0);
      bp.if_pc = rand_pc();
      epc = rand_pc();
      drive_br(epc, 1'($urandom_range(0, 1)),
               32'h0040_0000 + ($urandom_range(0, 15) << 2), 1'b0, 32'h0);
      bp.ex_valid     = ($urandom_range(0, 9) < 8);
      bp.ex_is_branch = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        model_predict(epc, mt, mtgt);
        bp.ex_pred_taken  = mt;
        bp.ex_pred_target = mtgt;
      end else begin
        bp.ex_pred_taken  = 1'($urandom_range(0, 1));
        bp.ex_pred_target = ($urandom_range(0, 1) == 1) ? bp.ex_target : epc + 32'd4;
      end
    end

    // Train a branch strongly taken, then reset mid-operation.
    rst = 1'b0;
    bp.if_pc = 32'h0040_0020;
    for (int i = 0; i < 3; i++) begin
      tick();
      drive_br(32'h0040_0020, 1'b1, 32'h0040_0080, 1'b0, 32'h0040_0024);
    end
    tick();
    idle();
    #2;
    check("pre_rst_taken", 64'(bp.pred_taken), 64'd1);
    tick();
    rst = 1'b1;
    drive_br(32'h0040_0020, 1'b1, 32'h0040_0900, 1'b0, 32'h0040_0024);
    #2;
    check("midrst_mispredict", 64'(bp.mispredict), 64'd0);
    tick();
    rst = 1'b0;
    idle();
    #2;
    check("midrst_forgotten",  64'(bp.pred_taken), 64'd0);
    check("midrst_branch_cnt", 64'(bp.branch_cnt), 64'd0);

    // Statistics wrap: 2**CNT_W-1 resolved not-taken branches, then one more.
    for (int i = 0; i < CNT_MOD - 1; i++) begin
      tick();
      drive_br(32'h0040_0300, 1'b0, 32'h0040_0000, 1'b0, 32'h0040_0304);
    end
    tick();
    #2;
    check("cnt_at_max", 64'(bp.branch_cnt), 64'(CNT_MOD - 1));
    tick();
    idle();
    #2;
    check("cnt_wrapped",     64'(bp.branch_cnt),  64'd0);
    check("cnt_no_mispred",  64'(bp.mispred_cnt), 64'd0);

    tick();
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
